// File: rtl/uart_capture_pkg.sv
// uart_capture_pkg: types and constants shared by the multi-channel UART capture block.
//   rx_state_e     - per-channel receiver FSM states (StParity only with UART_CAP_PARITY_EN)
//   fifo_entry_t   - capture FIFO entry {source channel, received byte}
//   EOT_CHAR_DEFAULT - default end-of-simulation character
// Optional feature macro: UART_CAP_PARITY_EN (adds the parity state).
package uart_capture_pkg;

    localparam logic [7:0]  EOT_CHAR_DEFAULT = 8'h04;
    // Channel field sized for the largest supported channel count (8).
    localparam int unsigned MAX_CH_W = 3;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
`ifdef UART_CAP_PARITY_EN
        , StParity
`endif
    } rx_state_e;

    typedef struct packed {
        logic [MAX_CH_W-1:0] ch;
        logic [7:0]          data;
    } fifo_entry_t;

endpackage

// File: rtl/uart_capture_rx.sv
// uart_capture_rx: one UART receive channel (8N1, or 8E1 with UART_CAP_PARITY_EN).
//   clk_i        - clock
//   rst_i        - asynchronous active-high reset
//   rxd_i        - raw serial input, idle high, asynchronous to clk_i
//   byte_done_o  - one-cycle strobe: a byte with a good stop bit (and parity) completed
//   byte_o       - received byte, valid with byte_done_o
//   frame_err_o  - registered one-cycle pulse on a bad stop bit or parity mismatch
// Optional feature macro: UART_CAP_PARITY_EN.
module uart_capture_rx
    import uart_capture_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic       byte_done_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int unsigned     CntW     = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLK_DIV / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLK_DIV - 1);

    logic [1:0]      sync_q;
    logic            rxd;
    rx_state_e       state_q, state_d;
    logic            armed_q, armed_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_err_q, frame_err_d;
`ifdef UART_CAP_PARITY_EN
    logic            par_ok_q, par_ok_d;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q      <= 2'b11;
            state_q     <= StIdle;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_CAP_PARITY_EN
            par_ok_q    <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], rxd_i};
            state_q     <= state_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
`ifdef UART_CAP_PARITY_EN
            par_ok_q    <= par_ok_d;
`endif
        end
    end

    assign rxd         = sync_q[1];
    assign byte_o      = shift_q;
    assign frame_err_o = frame_err_q;

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        cnt_d       = cnt_q + 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        byte_done_o = 1'b0;
`ifdef UART_CAP_PARITY_EN
        par_ok_d    = par_ok_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // A falling edge only counts once the line has been seen idle high.
                if (armed_q && !rxd) begin
                    state_d = StStart;
                    armed_d = 1'b0;
                end else if (rxd) begin
                    armed_d = 1'b1;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rxd, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_CAP_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_CAP_PARITY_EN
            StParity: begin
                if (cnt_q == BitLast) begin
                    cnt_d    = '0;
                    par_ok_d = (rxd == ^shift_q);
                    state_d  = StStop;
                end
            end
`endif
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    // A low stop bit leaves the line low, so re-arm only if it is high.
                    armed_d = rxd;
`ifdef UART_CAP_PARITY_EN
                    if (rxd && par_ok_q) begin
`else
                    if (rxd) begin
`endif
                        byte_done_o = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/uart_capture_mc.sv
// uart_capture_mc: NUM_CH UART receivers feeding one shared first-word-fall-through FIFO
// through per-channel hold registers and a round-robin arbiter.
//   CLK, RESET        - clock, asynchronous active-high reset
//   RXD               - serial inputs, one per channel
//   out_valid/ready   - FIFO head handshake; out_ch/out_data describe the head
//   clr_status        - clears the sticky overrun and sim_end flags
//   overrun           - sticky: a completed byte found its hold register still pending
//   frame_err         - one-cycle pulse per channel on a bad frame
//   sim_end           - sticky: EOT_CHAR was received on that channel
// Optional feature macro: UART_CAP_PARITY_EN (even parity bit, handled in uart_capture_rx).
module uart_capture_mc
    import uart_capture_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  EOT_CHAR   = EOT_CHAR_DEFAULT,
    localparam int unsigned ChW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] RXD,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ChW-1:0]    out_ch,
    output logic [7:0]        out_data,
    input  logic              clr_status,
    output logic [NUM_CH-1:0] overrun,
    output logic [NUM_CH-1:0] frame_err,
    output logic [NUM_CH-1:0] sim_end
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    logic [NUM_CH-1:0] done;
    logic [7:0]        rx_byte [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [7:0]        hold_q [NUM_CH];
    logic [7:0]        hold_d [NUM_CH];
    logic [NUM_CH-1:0] ovr_q, ovr_d, eot_q, eot_d;
    logic [ChW-1:0]    last_q, last_d;
    logic [NUM_CH-1:0] grant;
    logic              found;
    fifo_entry_t       push_entry;
    fifo_entry_t       mem_q [FIFO_DEPTH];
    logic [PtrW:0]     wr_q, rd_q;
    logic              empty, full, push, pop, can_push;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_rx
        uart_capture_rx #(
            .CLK_DIV(CLK_DIV)
        ) u_rx (
            .clk_i      (CLK),
            .rst_i      (RESET),
            .rxd_i      (RXD[g]),
            .byte_done_o(done[g]),
            .byte_o     (rx_byte[g]),
            .frame_err_o(frame_err[g])
        );
    end

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
    assign pop      = out_valid && out_ready;
    // A pop frees the slot the push writes into, so a full FIFO may still accept.
    assign can_push = !full || pop;
    assign push     = |grant;

    assign out_valid = !empty;
    assign out_ch    = out_valid ? ChW'(mem_q[rd_q[PtrW-1:0]].ch) : '0;
    assign out_data  = out_valid ? mem_q[rd_q[PtrW-1:0]].data : '0;
    assign overrun   = ovr_q;
    assign sim_end   = eot_q;

    // Round-robin: search starts at the channel after the last one granted.
    always_comb begin
        grant      = '0;
        found      = 1'b0;
        last_d     = last_q;
        push_entry = '0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (!found && can_push && pend_q[c] && ((32'(last_q) + off) % NUM_CH) == c) begin
                    found           = 1'b1;
                    grant[c]        = 1'b1;
                    last_d          = ChW'(c);
                    push_entry.ch   = MAX_CH_W'(c);
                    push_entry.data = hold_q[c];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            pend_d[c] = pend_q[c] & ~grant[c];
            hold_d[c] = hold_q[c];
            ovr_d[c]  = ovr_q[c] & ~clr_status;
            eot_d[c]  = eot_q[c] & ~clr_status;
            if (done[c]) begin
                if (pend_q[c]) begin
                    ovr_d[c] = 1'b1;
                end else begin
                    pend_d[c] = 1'b1;
                    hold_d[c] = rx_byte[c];
                end
                // EOT detection sees every completed byte, dropped or not.
                if (rx_byte[c] == EOT_CHAR) begin
                    eot_d[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pend_q <= '0;
            ovr_q  <= '0;
            eot_q  <= '0;
            last_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                hold_q[c] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
            eot_q  <= eot_d;
            last_q <= last_d;
            hold_q <= hold_d;
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_q[PtrW-1:0]] <= push_entry;
        end
    end

endmodule

// File: doc/uart_capture_mc.md
UART_CAPTURE_MC -- requirements
Module: uart_capture_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent UART RX channels (1..8).
REQ-002 SHALL have parameter CLK_DIV, default 16, CLK cycles per bit (even, >=4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, shared capture FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter EOT_CHAR, default 8'h04, end-of-simulation character.
REQ-005 SHALL have port CLK  in  1  sole clock; all logic is on its rising edge.
REQ-006 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port RXD  in  NUM_CH  serial inputs, idle high, asynchronous to CLK.
REQ-008 SHALL have port out_valid  out  1  FIFO head is valid.
REQ-009 SHALL have port out_ready  in  1  consumer accepts the head.
REQ-010 SHALL have port out_ch  out  $clog2(NUM_CH) (min 1)  source channel of the head.
REQ-011 SHALL have port out_data  out  8  received byte at the head.
REQ-012 SHALL have port clr_status  in  1  one-cycle pulse that clears the sticky flags.
REQ-013 SHALL have port overrun  out  NUM_CH  sticky flag: a byte was dropped.
REQ-014 SHALL have port frame_err  out  NUM_CH  one-cycle pulse on a bad stop bit.
REQ-015 SHALL have port sim_end  out  NUM_CH  sticky flag: EOT_CHAR was received.

Function
REQ-016 Each RXD bit SHALL pass a 2-flop synchronizer; all later references are to the synchronized value.
REQ-017 Per-channel FSM SHALL have states IDLE, START, DATA, STOP (plus PARITY, see Configuration).
REQ-018 IDLE SHALL arm only after seeing RXD high; an armed falling edge moves the FSM to START.
REQ-019 START SHALL wait CLK_DIV/2 cycles, then go to DATA if RXD is low, otherwise return to IDLE as a glitch.
REQ-020 DATA SHALL sample 8 bits LSB-first, one every CLK_DIV cycles, then go to STOP.
REQ-021 STOP SHALL sample after CLK_DIV cycles: high completes the byte; low pulses frame_err[ch] for 1 cycle and drops the byte; both cases return to IDLE.
REQ-022 A completed byte SHALL load the channel hold register; if the register is already pending, the new byte is dropped and overrun[ch] is set.
REQ-023 A round-robin arbiter SHALL move at most one pending hold register per cycle into the FIFO when it is not full; priority starts after the last granted channel.
REQ-024 The FIFO SHALL be first-word-fall-through; stop sample at cycle t -> hold pending at t+1 -> out_valid at t+2 if the FIFO was empty and the channel was granted.
REQ-025 out_ch/out_data SHALL be held stable while out_valid && !out_ready; the head pops on out_valid && out_ready.
REQ-026 When the FIFO is full, hold registers SHALL stay pending (backpressure); they never overwrite FIFO entries.
REQ-027 A simultaneous push and pop on a full FIFO SHALL be allowed, and occupancy stays the same.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit to tell full from empty.
REQ-029 sim_end[ch] SHALL set when a completed byte equals EOT_CHAR, regardless of overrun.
REQ-030 clr_status SHALL clear overrun and sim_end; if a set and clr_status coincide, the set wins.

Reset
REQ-031 RESET SHALL force all FSMs to IDLE (unarmed), synchronizers to 1, hold registers empty, the FIFO empty, and the arbiter pointer to 0.
REQ-032 During RESET, out_valid, out_ch, out_data, overrun, frame_err and sim_end SHALL all be 0.
REQ-033 RESET mid-frame SHALL discard the partial byte; after release, capture restarts at the next armed falling edge.

Configuration
REQ-034 With UART_CAP_PARITY_EN defined, a PARITY state SHALL sit between DATA and STOP and sample an even-parity bit.
REQ-035 A parity mismatch SHALL pulse frame_err[ch] and drop the byte.
REQ-036 Without UART_CAP_PARITY_EN, the frame SHALL be 10 bits and no parity logic is present.

Structure
REQ-037 A uart_capture_pkg SHALL hold the FSM state enum, the FIFO entry typedef {ch, data}, and the default EOT_CHAR constant.
REQ-038 The per-channel receiver SHALL be a sub-module uart_capture_rx, instantiated NUM_CH times; the arbiter and FIFO stay in the top level.

Verification (NUM_CH=2, CLK_DIV=8, FIFO_DEPTH=4)
REQ-039 Ch0 sends 8'hA5 with out_ready=1 -> out_valid at stop-sample+2 with out_ch=0, out_data=8'hA5, and no flags.
REQ-040 Both channels finish bytes 8'h11/8'h22 in the same cycle -> two consecutive entries in round-robin order, no overrun.
REQ-041 out_ready=0 while ch1 sends 6 bytes -> 4 entries in the FIFO, 1 pending, 1 dropped, overrun[1]=1; clr_status -> 0.
REQ-042 Ch0 stop bit driven low -> frame_err[0] pulses for exactly 1 cycle, no FIFO push, next frame received correctly.
REQ-043 Ch1 sends 8'h04 -> sim_end[1]=1 and remains set until clr_status; a 3-cycle low glitch on RXD[0] produces no byte.
REQ-044 RESET asserted mid-DATA on ch0 -> all outputs 0; after release, a new 8'h3C is captured intact.
